// File: rtl/vi_8b10b_pkg.sv
// -----------------------------------------------------------------------------
// vi_8b10b_pkg
//   Shared 8b/10b encoding constants and helpers.
//   - K code byte values
//   - 5b/6b and 3b/4b code tables for running disparity negative (RD-)
//   - is_valid_k() classifier
//   - enc_sym_t 10-bit symbol type
//
//   Table entries are written in transmission order: the 6b entries are
//   abcdei with 'a' as the MSB, and the 4b entries are fghj with 'f' as the MSB.
//   The lane encoder reverses them so that 'a' lands on symbol bit 0.
// -----------------------------------------------------------------------------
package vi_8b10b_pkg;

    typedef logic [9:0] enc_sym_t;

    // The twelve legal control characters.
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_1 = 8'h3C;
    localparam logic [7:0] K28_2 = 8'h5C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_4 = 8'h9C;
    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_6 = 8'hDC;
    localparam logic [7:0] K28_7 = 8'hFC;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K30_7 = 8'hFE;

    // 5b/6b data codes at RD-, indexed by EDCBA (abcdei order, a = MSB).
    localparam logic [5:0] D5B6B_RDM [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    // 6b code for K28 at RD-.
    localparam logic [5:0] K28_6B_RDM = 6'b001111;

    // 3b/4b data codes at RD-, indexed by HGF (fghj order, f = MSB).
    localparam logic [3:0] D3B4B_RDM [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    // 3b/4b codes following the K28 6b block, at RD-.
    localparam logic [3:0] K3B4B_RDM [8] = '{
        4'b1011, 4'b0110, 4'b1010, 4'b1100,
        4'b1101, 4'b0101, 4'b1001, 4'b0111
    };

    // Alternate x.7 code at RD-; also the tail of K23/27/29/30.7.
    localparam logic [3:0] A7_4B_RDM = 4'b0111;

    // K28.y for any y, or K23/27/29/30 with y = 7.
    function automatic logic is_valid_k(input logic [7:0] b);
        return (b[4:0] == 5'd28) ||
               ((b[7:5] == 3'd7) && (b[4:0] inside {5'd23, 5'd27, 5'd29, 5'd30}));
    endfunction

endpackage

// File: rtl/vi_enc8b10b_lane.sv
// -----------------------------------------------------------------------------
// vi_enc8b10b_lane
//   Combinational single-byte 8b/10b encoder (5b/6b then 3b/4b).
//   Ports:
//     dat    in  8   byte to encode (HGF_EDCBA)
//     k      in  1   control flag; an illegal K byte is sent as its D code
//     rd_in  in  1   running disparity before this symbol (0 = RD-, 1 = RD+)
//     sym    out 10  encoded symbol, a = bit 0 ... j = bit 9
//     rd_out out 1   running disparity after this symbol
//     kerr   out 1   k asserted on a byte that is not one of the 12 K codes
// -----------------------------------------------------------------------------
module vi_enc8b10b_lane
    import vi_8b10b_pkg::*;
(
    input  logic [7:0] dat,
    input  logic       k,
    input  logic       rd_in,
    output enc_sym_t   sym,
    output logic       rd_out,
    output logic       kerr
);

    logic [4:0] x;
    logic [2:0] y;
    logic       is_k;
    logic [5:0] six_m;
    logic [5:0] six;
    logic       six_bal;
    logic       rd_mid;
    logic       use_alt;
    logic [3:0] four_m;
    logic [3:0] four;
    logic       four_bal;

    always_comb begin
        x    = dat[4:0];
        y    = dat[7:5];
        is_k = k && is_valid_k(dat);
        kerr = k && !is_valid_k(dat);

        // 6b block: unbalanced codes are complemented at RD+. D.7 is balanced
        // but still has distinct RD-/RD+ forms (111000 / 000111).
        six_m   = (is_k && (x == 5'd28)) ? K28_6B_RDM : D5B6B_RDM[x];
        six_bal = ($countones(six_m) == 3);
        six     = (rd_in && (!six_bal || (x == 5'd7))) ? ~six_m : six_m;
        rd_mid  = six_bal ? rd_in : ~rd_in;

        // Alternate x.7 avoids a run of five equal bits across the 6b/4b seam.
        use_alt = (y == 3'd7) &&
                  (rd_mid ? (x inside {5'd11, 5'd13, 5'd14})
                          : (x inside {5'd17, 5'd18, 5'd20}));

        if (is_k) begin
            four_m = (x == 5'd28) ? K3B4B_RDM[y] : A7_4B_RDM;
        end else begin
            four_m = use_alt ? A7_4B_RDM : D3B4B_RDM[y];
        end
        four_bal = ($countones(four_m) == 2);

        // 4b block complement at RD+: every unbalanced code, D.x.3 (1100/0011),
        // and all K28 tails, whose balanced codes also swap with RD.
        four   = (rd_mid && (!four_bal || (!is_k && (y == 3'd3)) || (is_k && (x == 5'd28))))
                 ? ~four_m : four_m;
        rd_out = four_bal ? rd_mid : ~rd_mid;

        // Tables are abcdei/fghj with a/f as MSB; symbol bit 0 is 'a'.
        sym = {four[0], four[1], four[2], four[3],
               six[0], six[1], six[2], six[3], six[4], six[5]};
    end

endmodule

// File: rtl/vi_x4_encoder_8b10b.sv
// -----------------------------------------------------------------------------
// vi_x4_encoder_8b10b
//   Four-lane 8b/10b encoder: one 32-bit word plus 4 K flags per clock into
//   four 10b symbols, running disparity chained lane 0 -> 1 -> 2 -> 3.
//   Byte i = din_dat[8i+7:8i] -> dout_dat[10i+9:10i].
//
//   Parameter PIPE_STAGES (1 or 2): output register depth. Any other value
//   behaves as 1. The RD feedback loop is always a single cycle.
//
//   Build option VI_X4_ENC_KERR_EN: adds dout_kerr, a per-lane illegal-K flag
//   aligned with dout_dat and forced to 0 when dout_val is 0.
//
//   Ports:
//     clk          in   1   clock
//     rst          in   1   synchronous reset, active-high
//     din_ena      in   1   input word valid
//     din_dat      in   32  four data bytes
//     din_k        in   4   per-byte K flag
//     rd_force     in   1   load RD from rd_force_val (beats encode)
//     rd_force_val in   1   RD to load; 0 = negative, 1 = positive
//     dout_val     out  1   dout_dat valid
//     dout_dat     out  40  four 10b symbols
//     dout_rd      out  1   RD after lane 3 of the word on dout_dat
//                           (the forced value if a force hit that word)
//     dout_kerr    out  4   illegal K per lane (VI_X4_ENC_KERR_EN only)
// -----------------------------------------------------------------------------
module vi_x4_encoder_8b10b
    import vi_8b10b_pkg::*;
#(
    parameter int PIPE_STAGES = 1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        din_ena,
    input  logic [31:0] din_dat,
    input  logic [3:0]  din_k,
    input  logic        rd_force,
    input  logic        rd_force_val,
    output logic        dout_val,
    output logic [39:0] dout_dat,
    output logic        dout_rd
`ifdef VI_X4_ENC_KERR_EN
    ,
    output logic [3:0]  dout_kerr
`endif
);

    // rd_chain[0] is the registered RD; rd_chain[i+1] is lane i's output RD.
    logic [4:0] rd_chain;
    enc_sym_t   sym [4];
    logic [3:0] kerr_lane;

    logic        rd_q,   rd_d;
    logic        val1_q, val1_d;
    logic [39:0] dat1_q, dat1_d;
    logic        rdo1_q, rdo1_d;
`ifdef VI_X4_ENC_KERR_EN
    logic [3:0]  kerr1_q, kerr1_d;
`else
    logic        kerr_unused;
    assign kerr_unused = ^kerr_lane;
`endif

    assign rd_chain[0] = rd_q;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        vi_enc8b10b_lane u_lane (
            .dat    (din_dat[8*i +: 8]),
            .k      (din_k[i]),
            .rd_in  (rd_chain[i]),
            .sym    (sym[i]),
            .rd_out (rd_chain[i+1]),
            .kerr   (kerr_lane[i])
        );
    end

    // NOTE: every always_comb output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        rd_d   = rd_q;
        dat1_d = dat1_q;
        rdo1_d = rdo1_q;
        val1_d = din_ena;

        // Force beats encode; the word itself still uses the old RD via rd_chain.
        if (rd_force) begin
            rd_d = rd_force_val;
        end else if (din_ena) begin
            rd_d = rd_chain[4];
        end

        // Data holds across idle cycles; no idle characters are inserted.
        if (din_ena) begin
            dat1_d = {sym[3], sym[2], sym[1], sym[0]};
            rdo1_d = rd_d;
        end
`ifdef VI_X4_ENC_KERR_EN
        kerr1_d = din_ena ? kerr_lane : 4'b0000;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= 1'b0;
            val1_q  <= 1'b0;
            dat1_q  <= '0;
            rdo1_q  <= 1'b0;
`ifdef VI_X4_ENC_KERR_EN
            kerr1_q <= '0;
`endif
        end else begin
            rd_q    <= rd_d;
            val1_q  <= val1_d;
            dat1_q  <= dat1_d;
            rdo1_q  <= rdo1_d;
`ifdef VI_X4_ENC_KERR_EN
            kerr1_q <= kerr1_d;
`endif
        end
    end

    if (PIPE_STAGES == 2) begin : g_pipe2
        logic        val2_q, val2_d;
        logic [39:0] dat2_q, dat2_d;
        logic        rdo2_q, rdo2_d;
`ifdef VI_X4_ENC_KERR_EN
        logic [3:0]  kerr2_q, kerr2_d;
`endif

        always_comb begin
            val2_d = val1_q;
            dat2_d = val1_q ? dat1_q : dat2_q;
            rdo2_d = val1_q ? rdo1_q : rdo2_q;
`ifdef VI_X4_ENC_KERR_EN
            kerr2_d = kerr1_q;
`endif
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                val2_q  <= 1'b0;
                dat2_q  <= '0;
                rdo2_q  <= 1'b0;
`ifdef VI_X4_ENC_KERR_EN
                kerr2_q <= '0;
`endif
            end else begin
                val2_q  <= val2_d;
                dat2_q  <= dat2_d;
                rdo2_q  <= rdo2_d;
`ifdef VI_X4_ENC_KERR_EN
                kerr2_q <= kerr2_d;
`endif
            end
        end

        assign dout_val  = val2_q;
        assign dout_dat  = dat2_q;
        assign dout_rd   = rdo2_q;
`ifdef VI_X4_ENC_KERR_EN
        assign dout_kerr = kerr2_q;
`endif
    end else begin : g_pipe1
        assign dout_val  = val1_q;
        assign dout_dat  = dat1_q;
        assign dout_rd   = rdo1_q;
`ifdef VI_X4_ENC_KERR_EN
        assign dout_kerr = kerr1_q;
`endif
    end

endmodule
